// File: rtl/prog_imem_pkg.sv
// Shared types and constants for the program-loadable instruction memory.
package prog_imem_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  // MOV R0,R0: harmless filler returned for faulting fetches.
  localparam logic [31:0] NOP_WORD_DEF = 32'hE1A00000;

  localparam int LANE_W = 8;

  function automatic int byte_lanes(input int data_w);
    return data_w / LANE_W;
  endfunction

  localparam int BYTE_LANES = byte_lanes(32);

endpackage

// File: rtl/prog_imem_if.sv
// Fetch read port and byte-serial loader port of the instruction memory.
interface prog_imem_if #(
  parameter int DEPTH_LOG2 = 6,
  parameter int DATA_W     = 32
);
  import prog_imem_pkg::*;

  logic                  rd_en;
  logic [31:0]           rd_addr;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;
  logic                  rd_fault;

  // Loader handshake: a byte (with its ld_last flag) transfers at a rising
  // edge where ld_valid && ld_ready. The source may raise ld_valid without
  // waiting for ld_ready and must hold ld_byte/ld_last stable until the transfer.
  logic                  ld_start;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [7:0]            ld_byte;
  logic                  ld_last;
  logic                  ld_done;
  logic                  busy;
  logic [DEPTH_LOG2:0]   loaded_words;

  state_t                dbg_state;

  modport master (
    output rd_en, rd_addr, ld_start, ld_valid, ld_byte, ld_last,
    input  rd_data, rd_valid, rd_fault, ld_ready, ld_done, busy,
           loaded_words, dbg_state
  );

  modport slave (
    input  rd_en, rd_addr, ld_start, ld_valid, ld_byte, ld_last,
    output rd_data, rd_valid, rd_fault, ld_ready, ld_done, busy,
           loaded_words, dbg_state
  );

endinterface

// File: rtl/prog_imem_ram.sv
// Simple dual-port storage: one synchronous write, one registered read.
module prog_imem_ram #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  // Read-before-write on a same-address collision.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/prog_imem.sv
// Instruction memory with a byte-serial program loader and a gated fetch port.
module prog_imem
  import prog_imem_pkg::*;
#(
  parameter int                DEPTH_LOG2 = 6,
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] NOP_WORD   = DATA_W'(NOP_WORD_DEF)
) (
  input  logic       clk,
  input  logic       reset_n,
  prog_imem_if.slave bus
);

  localparam int DEPTH  = 2**DEPTH_LOG2;
  localparam int LANES  = byte_lanes(DATA_W);
  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] CNT_LAST = (DEPTH_LOG2+1)'(DEPTH-1);
  localparam logic [LIDX_W-1:0]   IDX_ONE  = LIDX_W'(1);
  localparam logic [LIDX_W-1:0]   IDX_LAST = LIDX_W'(LANES-1);

  state_t              r_state;
  state_t              w_next_state;
  logic                w_busy;
  logic                w_ready;

  logic [DEPTH_LOG2:0] r_wptr;
  logic [DEPTH_LOG2:0] r_loaded;
  logic [LIDX_W-1:0]   r_byte_idx;
  logic [DATA_W-1:0]   r_word;
  logic                r_done;

  logic                w_accept;
  logic                w_wr;
  logic                w_finish;
  logic [DATA_W-1:0]   w_asm;

  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic                w_rd_fault;
  logic                r_rd_valid;
  logic                r_rd_fault;
  logic                r_rd_hit;
  logic [DATA_W-1:0]   w_ram_q;

  // A restart pulse wins over a byte offered in the same cycle.
  assign w_accept = w_ready && bus.ld_valid && !bus.ld_start;
  assign w_wr     = w_accept && ((r_byte_idx == IDX_LAST) || bus.ld_last);
  assign w_finish = w_accept && (bus.ld_last || (w_wr && (r_wptr == CNT_LAST)));

  always_comb begin
    w_asm = r_word;
    w_asm[int'(r_byte_idx)*8 +: 8] = bus.ld_byte;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (bus.ld_start) w_next_state = ST_LOAD;
      ST_LOAD: begin
        if (bus.ld_start)  w_next_state = ST_LOAD;
        else if (w_finish) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy  = 1'b0;
    w_ready = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_busy  = 1'b1;
        w_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // Upper lanes of r_word are kept zero so a short final word is zero-padded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_loaded   <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (bus.ld_start) begin
        r_wptr     <= '0;
        r_loaded   <= '0;
        r_byte_idx <= '0;
        r_word     <= '0;
      end else if (w_accept) begin
        if (w_wr) begin
          r_wptr     <= r_wptr + CNT_ONE;
          r_loaded   <= r_loaded + CNT_ONE;
          r_byte_idx <= '0;
          r_word     <= '0;
        end else begin
          r_byte_idx <= r_byte_idx + IDX_ONE;
          r_word     <= w_asm;
        end
      end
    end
  end

  assign w_rd_idx   = bus.rd_addr[DEPTH_LOG2+1:2];
  assign w_rd_fault = (|bus.rd_addr[31:DEPTH_LOG2+2])
                   || ({1'b0, w_rd_idx} >= r_loaded)
                   || (r_state == ST_LOAD);

  // r_rd_hit keeps the uninitialised RAM output off rd_data until a first read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid <= 1'b0;
      r_rd_fault <= 1'b0;
      r_rd_hit   <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        r_rd_fault <= w_rd_fault;
        r_rd_hit   <= 1'b1;
      end
    end
  end

  prog_imem_ram #(
    .AW (DEPTH_LOG2),
    .DW (DATA_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wptr[DEPTH_LOG2-1:0]),
    .i_wdata (w_asm),
    .i_re    (bus.rd_en),
    .i_raddr (w_rd_idx),
    .o_rdata (w_ram_q)
  );

  assign bus.rd_valid     = r_rd_valid;
  assign bus.rd_fault     = r_rd_fault;
  assign bus.rd_data      = r_rd_fault ? NOP_WORD : (r_rd_hit ? w_ram_q : '0);
  assign bus.ld_ready     = w_ready;
  assign bus.ld_done      = r_done;
  assign bus.busy         = w_busy;
  assign bus.loaded_words = r_loaded;
  assign bus.dbg_state    = r_state;

endmodule

// File: doc/prog_imem.md
Name: prog_imem

Overview:
- Parametrised instruction memory for the ARM core, with a synchronous read port and a byte-serial program loader.
- Programs are streamed in after reset (from the bench or a debug UART) instead of being hard-coded as ROM constants.
- Sits between the fetch stage (read port) and the load source (load port).
- One clock domain, no external memory.

Parameters:
- DEPTH_LOG2, 6, word depth is 2**DEPTH_LOG2 (64 words).
- DATA_W, 32, instruction word width; must be a multiple of 8.
- NOP_WORD, 32'hE1A00000, word returned for out-of-range or not-yet-loaded reads (MOV R0,R0).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- rd_en  in  1  fetch request.
- rd_addr  in  32  byte address; word aligned, bits [1:0] ignored.
- rd_data  out  DATA_W  instruction word, valid with rd_valid.
- rd_valid  out  1  high one cycle after an accepted rd_en.
- rd_fault  out  1  qualifies rd_valid: address was out of range or beyond the load high-water mark.
- ld_start  in  1  pulse: begin a new program load.
- ld_valid  in  1  byte handshake valid.
- ld_ready  out  1  byte handshake ready.
- ld_byte  in  8  program byte, little-endian within each word.
- ld_last  in  1  marks the final byte of the program.
- ld_done  out  1  one-cycle pulse when the load completes.
- busy  out  1  high while in LOAD state.
- loaded_words  out  DEPTH_LOG2+1  count of words written by the last load.

Behaviour:
Reset (async assert, sync release):
- State = IDLE; all outputs 0.
- Write pointer, byte lane and loaded_words cleared.
- RAM contents are not reset. Reads are gated by loaded_words, so unloaded words read as NOP_WORD with rd_fault=1.

States:
- IDLE:
  - ld_start -> LOAD.
  - Reads are served normally.
- LOAD:
  - ld_ready=1 and busy=1.
  - A byte is accepted on ld_valid&&ld_ready and written into lane byte_idx of a word shift register; byte_idx increments.
  - When byte_idx wraps 3->0, the assembled word is written to RAM[wptr], then wptr and loaded_words increment.
  - If ld_last is accepted on a partial word: the word is zero-padded in its upper lanes, written, and counted.
  - After ld_last: ld_done=1 for exactly one cycle (the cycle after the last accepted byte) -> IDLE.
  - Full: when wptr reaches 2**DEPTH_LOG2, the load finishes as if ld_last arrived. ld_ready drops in the cycle the final word is written; later bytes are not accepted. ld_done pulses and the state returns to IDLE.
  - ld_start during LOAD restarts the load: wptr, byte_idx and loaded_words go to 0, and the partial word is discarded. This takes priority over a byte accepted in the same cycle.
- ld_start while in IDLE also clears loaded_words before the first byte.

Read port:
- Registered read, latency 1: rd_en at edge N gives rd_valid=1 after edge N+1, with rd_data = RAM[rd_addr[DEPTH_LOG2+1:2]].
- rd_valid=0 when rd_en=0 the previous cycle.
- rd_data holds its last value when rd_valid=0.
- Out of range (rd_addr[31:DEPTH_LOG2+2] != 0) or word index >= loaded_words: rd_data=NOP_WORD, rd_fault=1.
- During LOAD, reads are still served but always fault (return NOP_WORD). The core must be held in reset until ld_done.
- Same-cycle RAM write and read of the same word: the read returns the old content. This cannot occur outside LOAD, because of the fault rule.

Decomposition:
- Package prog_imem_pkg: state enum (IDLE, LOAD), the NOP_WORD default, and the byte-lane count localparam.
- Sub-module prog_imem_ram: a simple synchronous single-port-write, single-port-read array, isolated for FPGA BRAM inference.
- FSM, assembler and read gating live in the top module.

Test Plan:
- Reset, then rd_en with rd_addr=0 -> next cycle rd_valid=1, rd_fault=1, rd_data=E1A00000; loaded_words=0.
- Load the bytes 00,00,00,EB, 08,00,80,E2, 01,10,41,E0, 08,00,40,E2 with ld_last on the final byte:
  - ld_done pulses once; loaded_words=4.
  - Reads at addresses 0/4/8/C return EB000000, E2800008, E0411001, E2400008 with rd_fault=0.
  - Read at address 0x10 returns NOP with fault.
- Partial word: load 5 bytes (11,22,33,44,55, last) -> loaded_words=2; word1=00000055.
- Full: stream 260 bytes with no ld_last:
  - Exactly 256 bytes are accepted; ld_ready falls after the 256th byte.
  - ld_done pulses; loaded_words=64.
  - Reading address 0xFC returns the last word.
  - Reading address 0x100 faults.
- Restart: ld_start after 6 bytes, then a 4-byte load of AA,BB,CC,DD -> loaded_words=1, word0=DDCCBBAA.
- Async reset mid-load: assert reset_n=0 after 3 bytes, with no clock edge -> busy=0 immediately; loaded_words=0; read of word 0 faults.
- Backpressure and gaps: randomly toggle ld_valid -> assembled words are identical to the gap-free run.
